// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, drives the instruction memory address
// and registers the returned word into the IF/ID register. A two-state FSM
// parks the stage in HALT after a bad fetch address until a redirect arrives.
module instr_fetch #(
    parameter int          MEM_WORDS = 14,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] pc_addr_o,
    input  logic [31:0] instr_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        flush_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        valid_o,
    output logic        halted_o,
    output logic        addr_err_o,
    output logic [31:0] fetch_cnt_o
);

    // First byte address past the end of the attached memory.
    localparam logic [31:0] PC_LIMIT = 32'(4 * MEM_WORDS);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pc_q;
    logic        in_range;

    // The memory address is the PC itself, so the fetched word lines up with pc_q.
    assign pc_addr_o = pc_q;
    assign in_range  = (pc_q < PC_LIMIT) && (pc_q[1:0] == 2'b00);
    assign halted_o  = (state == HALT);

    // PC, FSM and IF/ID register with redirect > flush > stall > advance priority.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q        <= RESET_PC;
            state       <= RUN;
            instr_o     <= 32'h0;
            pc_o        <= 32'h0;
            pc_plus4_o  <= 32'h0;
            valid_o     <= 1'b0;
            addr_err_o  <= 1'b0;
            fetch_cnt_o <= 32'h0;
        end else if (redirect_i) begin
            // Low target bits are dropped; a misaligned target is flagged, not trapped.
            pc_q    <= {redirect_pc_i[31:2], 2'b00};
            valid_o <= 1'b0;
            state   <= RUN;
            if (redirect_pc_i[1:0] != 2'b00) begin
                addr_err_o <= 1'b1;
            end
        end else if (flush_i) begin
            valid_o <= 1'b0;
        end else if (stall_i) begin
            valid_o <= valid_o;
        end else begin
            case (state)
                RUN: begin
                    if (in_range) begin
                        instr_o     <= instr_i;
                        pc_o        <= pc_q;
                        pc_plus4_o  <= pc_q + 32'd4;
                        valid_o     <= 1'b1;
                        pc_q        <= pc_q + 32'd4;
                        fetch_cnt_o <= fetch_cnt_o + 32'd1;
                    end else begin
                        state      <= HALT;
                        addr_err_o <= 1'b1;
                        valid_o    <= 1'b0;
                        instr_o    <= 32'h0;
                    end
                end
                HALT: begin
                    valid_o <= 1'b0;
                end
                default: begin
                    state <= HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch: a combinational memory model returns
// 32'h0000_1000 + word index for the 14 words, and a filler word outside them.
module tb_instr_fetch;

    logic        clk_i;
    logic        rst_i;
    logic [31:0] pc_addr_o;
    logic [31:0] instr_i;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        flush_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        valid_o;
    logic        halted_o;
    logic        addr_err_o;
    logic [31:0] fetch_cnt_o;

    int vectors;
    int miscompares;

    logic [29:0] word_idx;

    instr_fetch #(
        .MEM_WORDS(14),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .pc_addr_o    (pc_addr_o),
        .instr_i      (instr_i),
        .stall_i      (stall_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .flush_i      (flush_i),
        .instr_o      (instr_o),
        .pc_o         (pc_o),
        .pc_plus4_o   (pc_plus4_o),
        .valid_o      (valid_o),
        .halted_o     (halted_o),
        .addr_err_o   (addr_err_o),
        .fetch_cnt_o  (fetch_cnt_o)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Instruction memory model.
    assign word_idx = pc_addr_o[31:2];
    assign instr_i  = (word_idx < 30'd14) ? (32'h0000_1000 + {2'b00, word_idx}) : 32'hBAD0_0BAD;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Linear directed sequence.
    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst_i         = 1'b1;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        flush_i       = 1'b0;

        #2;
        check("rst_pc_addr",  pc_addr_o,   32'h0);
        check("rst_instr",    instr_o,     32'h0);
        check("rst_pc",       pc_o,        32'h0);
        check("rst_pc_plus4", pc_plus4_o,  32'h0);
        check("rst_valid",    {31'b0, valid_o},    32'h0);
        check("rst_halted",   {31'b0, halted_o},   32'h0);
        check("rst_addr_err", {31'b0, addr_err_o}, 32'h0);
        check("rst_cnt",      fetch_cnt_o, 32'h0);

        step();
        rst_i = 1'b0;
        check("first_fetch_addr", pc_addr_o, 32'h0);
        check("no_valid_yet", {31'b0, valid_o}, 32'h0);

        // Free-running fetches A, B.
        step();
        check("fetch_a_instr", instr_o, 32'h0000_1000);
        check("fetch_a_pc",    pc_o,    32'h0);
        check("fetch_a_valid", {31'b0, valid_o}, 32'h1);
        check("fetch_a_plus4", pc_plus4_o, 32'h4);
        step();
        check("fetch_b_instr", instr_o, 32'h0000_1001);
        check("fetch_b_pc",    pc_o,    32'h4);
        check("fetch_b_addr",  pc_addr_o, 32'h8);

        // Two-cycle stall holds everything.
        stall_i = 1'b1;
        step();
        step();
        check("stall_instr", instr_o,     32'h0000_1001);
        check("stall_pc",    pc_o,        32'h4);
        check("stall_addr",  pc_addr_o,   32'h8);
        check("stall_cnt",   fetch_cnt_o, 32'd2);
        check("stall_valid", {31'b0, valid_o}, 32'h1);
        stall_i = 1'b0;

        step();
        check("fetch_c_instr", instr_o,     32'h0000_1002);
        check("fetch_c_pc",    pc_o,        32'h8);
        check("fetch_c_cnt",   fetch_cnt_o, 32'd3);

        // Redirect wins over a simultaneous stall.
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h10;
        stall_i       = 1'b1;
        step();
        redirect_i = 1'b0;
        stall_i    = 1'b0;
        check("redir_bubble", {31'b0, valid_o}, 32'h0);
        check("redir_addr",   pc_addr_o, 32'h10);
        check("redir_cnt",    fetch_cnt_o, 32'd3);
        step();
        check("redir_pc",    pc_o,    32'h10);
        check("redir_valid", {31'b0, valid_o}, 32'h1);
        check("redir_instr", instr_o, 32'h0000_1004);
        check("redir_plus4", pc_plus4_o, 32'h14);
        check("redir_cnt2",  fetch_cnt_o, 32'd4);

        // Advance 20..52, leaving pc_q at the first out-of-range address.
        for (int i = 0; i < 9; i++) step();
        check("last_pc",    pc_o,        32'd52);
        check("last_instr", instr_o,     32'h0000_100D);
        check("end_addr",   pc_addr_o,   32'd56);
        check("end_cnt",    fetch_cnt_o, 32'd13);
        check("end_halted", {31'b0, halted_o}, 32'h0);
        step();
        check("halt_halted",   {31'b0, halted_o},   32'h1);
        check("halt_addr_err", {31'b0, addr_err_o}, 32'h1);
        check("halt_valid",    {31'b0, valid_o},    32'h0);
        check("halt_instr",    instr_o,   32'h0);
        check("halt_addr",     pc_addr_o, 32'd56);
        step();
        check("halt_hold_addr",  pc_addr_o,   32'd56);
        check("halt_hold_state", {31'b0, halted_o}, 32'h1);
        check("halt_hold_cnt",   fetch_cnt_o, 32'd13);

        // Redirect out of HALT; the error flag stays sticky.
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0;
        step();
        redirect_i = 1'b0;
        check("resume_halted",   {31'b0, halted_o},   32'h0);
        check("resume_addr",     pc_addr_o, 32'h0);
        check("resume_addr_err", {31'b0, addr_err_o}, 32'h1);
        step();
        check("resume_instr", instr_o,     32'h0000_1000);
        check("resume_cnt",   fetch_cnt_o, 32'd14);

        // Misaligned redirect target is aligned down.
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h6;
        step();
        redirect_i = 1'b0;
        check("misalign_addr",  pc_addr_o, 32'h4);
        check("misalign_valid", {31'b0, valid_o}, 32'h0);
        step();
        check("misalign_pc",  pc_o,      32'h4);
        check("misalign_nxt", pc_addr_o, 32'h8);
        check("misalign_cnt", fetch_cnt_o, 32'd15);

        // Flush pulse: bubble without moving the PC; stall is ignored.
        flush_i = 1'b1;
        stall_i = 1'b1;
        step();
        flush_i = 1'b0;
        stall_i = 1'b0;
        check("flush_valid", {31'b0, valid_o}, 32'h0);
        check("flush_addr",  pc_addr_o, 32'h8);
        check("flush_pc",    pc_o,      32'h4);
        check("flush_cnt",   fetch_cnt_o, 32'd15);
        step();
        check("post_flush_valid", {31'b0, valid_o}, 32'h1);
        check("post_flush_pc",    pc_o,    32'h8);
        check("post_flush_instr", instr_o, 32'h0000_1002);

        // Enter HALT via an out-of-range redirect, then reset between edges.
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h40;
        step();
        redirect_i = 1'b0;
        check("oor_addr", pc_addr_o, 32'h40);
        step();
        check("oor_halted", {31'b0, halted_o}, 32'h1);
        #2;
        rst_i = 1'b1;
        #1;
        check("async_rst_halted",   {31'b0, halted_o},   32'h0);
        check("async_rst_addr_err", {31'b0, addr_err_o}, 32'h0);
        check("async_rst_addr",     pc_addr_o,   32'h0);
        check("async_rst_cnt",      fetch_cnt_o, 32'h0);
        check("async_rst_pc",       pc_o,        32'h0);
        check("async_rst_plus4",    pc_plus4_o,  32'h0);
        check("async_rst_instr",    instr_o,     32'h0);
        check("async_rst_valid",    {31'b0, valid_o}, 32'h0);

        // Misaligned redirect from a clean error flag sets it.
        step();
        rst_i         = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h6;
        step();
        redirect_i = 1'b0;
        check("fresh_misalign_err",  {31'b0, addr_err_o}, 32'h1);
        check("fresh_misalign_addr", pc_addr_o, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter MEM_WORDS, default 14, giving the number of 32-bit words in the attached instruction memory.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-003 Port clk_i  input  1  system clock; all state updates on the rising edge.
REQ-004 Port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 Port pc_addr_o  output  32  byte address driven to the instruction memory; the memory returns the word at pc_addr_o/4 combinationally.
REQ-006 Port instr_i  input  32  instruction word returned by the memory for the current pc_addr_o.
REQ-007 Port stall_i  input  1  decode not ready; hold PC and the IF/ID outputs.
REQ-008 Port redirect_i  input  1  branch/jump taken; load redirect_pc_i into the PC.
REQ-009 Port redirect_pc_i  input  32  target byte address for redirect_i.
REQ-010 Port flush_i  input  1  invalidate the IF/ID register without changing the PC.
REQ-011 Port instr_o  output  32  registered instruction (IF/ID).
REQ-012 Port pc_o  output  32  registered address of instr_o.
REQ-013 Port pc_plus4_o  output  32  registered pc_o+4.
REQ-014 Port valid_o  output  1  instr_o/pc_o hold a real fetched instruction.
REQ-015 Port halted_o  output  1  FSM is in HALT.
REQ-016 Port addr_err_o  output  1  sticky; an out-of-range or misaligned fetch address has occurred.
REQ-017 Port fetch_cnt_o  output  32  count of instructions delivered with valid_o=1.

Function
REQ-018 pc_addr_o SHALL equal the internal PC register (pc_q) combinationally, with no added latency.
REQ-019 The FSM SHALL have two states: RUN and HALT.
REQ-020 A fetch address SHALL be in range when pc_q < 4*MEM_WORDS and pc_q[1:0]==2'b00.
REQ-021 Per-edge priority SHALL be: rst_i, then redirect_i, then flush_i, then stall_i, then normal advance.
REQ-022 On redirect_i=1 (either state):
  - pc_q <= {redirect_pc_i[31:2],2'b00};
  - valid_o <= 0, a one-cycle bubble;
  - state <= RUN;
  - if redirect_pc_i[1:0]!=0, addr_err_o <= 1.
  - stall_i is ignored in that cycle.
REQ-023 On flush_i=1 with redirect_i=0: valid_o <= 0; pc_q and the other IF/ID fields hold; stall_i is ignored.
REQ-024 On stall_i=1 with no redirect or flush, pc_q, instr_o, pc_o, pc_plus4_o, valid_o and fetch_cnt_o SHALL all hold.
REQ-025 On a normal advance in RUN with an in-range pc_q:
  - instr_o <= instr_i; pc_o <= pc_q; pc_plus4_o <= pc_q+4; valid_o <= 1;
  - pc_q <= pc_q+4 (modulo 2^32).
REQ-026 In RUN with an out-of-range pc_q and no redirect, flush or stall:
  - state <= HALT; addr_err_o <= 1; valid_o <= 0;
  - instr_o <= 32'h0; pc_q holds.
REQ-027 In HALT with no redirect: pc_q holds, valid_o stays 0, and instr_i is ignored.
REQ-028 fetch_cnt_o SHALL increment by 1 on each edge that loads valid_o <= 1, and wrap from 32'hFFFF_FFFF to 0.
REQ-029 addr_err_o SHALL clear only on reset.
REQ-030 halted_o SHALL be 1 exactly when state==HALT.

Reset
REQ-031 While rst_i=1, independent of clk_i:
  - pc_q = RESET_PC; state = RUN;
  - instr_o, pc_o and pc_plus4_o = 0;
  - valid_o, halted_o and addr_err_o = 0; fetch_cnt_o = 0.
REQ-032 The first fetch SHALL be issued from RESET_PC in the first cycle after rst_i deasserts, and valid_o SHALL first rise at the edge after that cycle.
REQ-033 Asserting rst_i mid-stall, mid-redirect or in HALT SHALL immediately force the reset values of REQ-031.

Verification
REQ-034 Reset, then 3 free-running edges with a memory model holding words A,B,C at 0,4,8 -> (instr_o,pc_o) = (A,0),(B,4),(C,8); fetch_cnt_o=3.
REQ-035 Stall for 2 cycles while instr_o=B and pc_q=8 -> instr_o=B, pc_o=4, pc_addr_o=8 held; fetch_cnt_o unchanged.
REQ-036 redirect_i=1, redirect_pc_i=32'h10, together with stall_i=1 -> next edge: valid_o=0, pc_addr_o=16; following edge: pc_o=16, valid_o=1.
REQ-037 Run to pc_q=56 with MEM_WORDS=14:
  - expect halted_o=1, addr_err_o=1, valid_o=0, pc_addr_o stays 56;
  - then redirect to 0 -> RUN, with addr_err_o still 1.
REQ-038 redirect_pc_i=32'h6 -> pc_addr_o=4, addr_err_o=1; flush_i pulse -> valid_o=0 for 1 cycle, pc_addr_o unchanged.
REQ-039 Assert rst_i asynchronously between edges while halted -> outputs take REQ-031 values before the next clock edge.
